// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
// The priority encoder is used by the event emitter to walk the change mask.
package keypad_pkg;

  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam int         EVT_W     = 5;
  localparam logic       EVT_PRESS = 1'b1;

  typedef enum logic {
    SCAN = 1'b0,
    EMIT = 1'b1
  } scan_state_e;

  // Index of the lowest set bit; returns 0 for an all-zero input.
  function automatic logic [3:0] lowest_set_16(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous event FIFO with full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module keypad_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with frame debounce and a queued press/release event port.
//   state | meaning
//   SCAN  | drive one row per dwell, sample columns, debounce complete frames
//   EMIT  | push one event per cycle for each changed key, rows frozen
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 2500,
  parameter int DEB_FRAMES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [3:0]       col,
  output logic [3:0]       row,
  output logic [15:0]      key_state,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_code,
  input  logic             evt_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             irq
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(DEB_FRAMES - 1);

  scan_state_e state, state_n;
  logic [3:0]    col_s1, col_s2;
  logic          run;
  logic [1:0]    ri, ri_n;
  logic [CW-1:0] dwell, dwell_n;
  logic [SW-1:0] stab, stab_n;
  logic [15:0]   raw, raw_n;
  logic [15:0]   prev_raw, prev_raw_n;
  logic [15:0]   key_q, key_n;
  logic [15:0]   diff, diff_n;
  logic [15:0]   frame;
  logic [3:0]    idx;
  logic          push;
  logic [EVT_W-1:0] push_code;
  logic          fifo_empty, fifo_full;
  logic          drop;
  logic          overflow_q, irq_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= SCAN;
      col_s1     <= 4'hF;
      col_s2     <= 4'hF;
      run        <= 1'b0;
      ri         <= '0;
      dwell      <= DWELL_LAST;
      stab       <= '0;
      raw        <= '0;
      prev_raw   <= '0;
      key_q      <= '0;
      diff       <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state    <= state_n;
      col_s1   <= col;
      col_s2   <= col_s1;
      run      <= en;
      ri       <= ri_n;
      dwell    <= dwell_n;
      stab     <= stab_n;
      raw      <= raw_n;
      prev_raw <= prev_raw_n;
      key_q    <= key_n;
      diff     <= diff_n;
      irq_q    <= !fifo_empty;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  // The dwell timer counts down from SCAN_DIV-1; terminal count 0 is the sample point.
  always_comb begin
    state_n    = state;
    ri_n       = ri;
    dwell_n    = dwell;
    stab_n     = stab;
    raw_n      = raw;
    prev_raw_n = prev_raw;
    key_n      = key_q;
    diff_n     = diff;
    frame      = raw;
    idx        = '0;
    push       = 1'b0;
    push_code  = '0;
    case (state)
      SCAN: begin
        if (!run) begin
          ri_n       = '0;
          dwell_n    = DWELL_LAST;
          stab_n     = '0;
          prev_raw_n = '0;
        end else if (dwell == '0) begin
          frame[{ri, 2'b00} +: 4] = ~col_s2;
          raw_n   = frame;
          ri_n    = ri + 2'd1;
          dwell_n = DWELL_LAST;
          if (ri == 2'd3) begin
            if (frame == prev_raw) stab_n = (stab == STAB_MAX) ? stab : stab + SW'(1);
            else                   stab_n = '0;
            prev_raw_n = frame;
            if (stab_n == STAB_MAX && frame != key_q) begin
              diff_n  = frame ^ key_q;
              key_n   = frame;
              state_n = EMIT;
            end
          end
        end else begin
          dwell_n = dwell - CW'(1);
        end
      end
      EMIT: begin
        idx       = lowest_set_16(diff);
        push      = 1'b1;
        push_code = {(key_q[idx] ? EVT_PRESS : ~EVT_PRESS), idx};
        diff_n    = diff & ~(16'h0001 << idx);
        if (diff_n == '0) begin
          state_n = SCAN;
          dwell_n = DWELL_LAST;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_code),
    .pop   (evt_ready),
    .dout  (evt_code),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign drop      = push && fifo_full && !(evt_ready && !fifo_empty);
  assign row       = (state == EMIT || run) ? ~(4'b0001 << ri) : ROW_IDLE;
  assign key_state = key_q;
  assign evt_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign irq       = irq_q;

endmodule
